// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB-Lite slave fronting a byte-writable 32-bit SRAM.
//               Accepts byte/halfword/word transfers, inserts a fixed number
//               of wait states per OKAY data phase, and produces the
//               two-cycle AHB ERROR response for misaligned, oversize or
//               out-of-range accesses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_WORDS   : number of 32-bit storage words (byte window 0..MEM_WORDS*4-1)
//   WAIT_STATES : HREADYOUT-low cycles inserted in every OKAY data phase
// Ports
//   HCLK       in   clock, rising edge
//   HRESET     in   asynchronous active-high reset
//   HSEL       in   slave select
//   HADDR      in   16-bit byte address (address phase)
//   HTRANS     in   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   HWRITE     in   1 = write
//   HSIZE      in   0 = byte, 1 = halfword, 2 = word
//   HBURST     in   unused
//   HPROT      in   unused
//   HWDATA     in   write data (data phase)
//   HREADY     in   bus ready, previous transfer complete
//   HRDATA     out  read data, zero outside a read's final data cycle
//   HREADYOUT  out  slave ready
//   HRESP      out  0 = OKAY, 1 = ERROR
// ============================================================================
module ahb_sram_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [15:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int          c_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int          c_CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int unsigned c_BYTES = MEM_WORDS * 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [c_AW-1:0]   r_widx;
    logic [1:0]        r_lane;
    logic [1:0]        r_size;
    logic              r_write;
    logic              r_hreadyout;
    logic              r_hresp;
    logic [31:0]       r_rdbuf;
    logic [31:0]       r_mem [MEM_WORDS];

    logic              w_sel_xfer;
    logic              w_busy;
    logic              w_accept;
    logic              w_err;
    logic              w_final;
    logic              w_commit;
    logic [c_AW-1:0]   w_aidx;
    logic [3:0]        w_be;

    // Burst/protection attributes and the NONSEQ/SEQ distinction carry no meaning here.
    logic              w_unused_ok;
    assign w_unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    assign w_sel_xfer = HSEL & HTRANS[1] & HREADY;
    // Inside ERR1 or a wait cycle the slave itself holds HREADY low; the guard
    // keeps a misbehaving master from corrupting an in-flight data phase.
    assign w_busy     = (r_state == S_ERR1) || ((r_state == S_DATA) && (r_cnt != '0));
    assign w_accept   = w_sel_xfer & ~w_busy;
    assign w_aidx     = HADDR[c_AW+1:2];

    assign w_err = (HSIZE > 3'd2)
                 | ((HSIZE == 3'd1) & HADDR[0])
                 | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                 | ({16'd0, HADDR} >= c_BYTES);

    assign w_final  = (r_state == S_DATA) && (r_cnt == '0);
    assign w_commit = w_final & r_write;

    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            2'd0:    w_be[r_lane] = 1'b1;
            2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer FSM with registered HREADYOUT/HRESP
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_widx      <= '0;
            r_lane      <= 2'd0;
            r_size      <= 2'd0;
            r_write     <= 1'b0;
        end else if (w_accept) begin
            r_widx  <= w_aidx;
            r_lane  <= HADDR[1:0];
            r_size  <= HSIZE[1:0];
            r_write <= HWRITE;
            if (w_err) begin
                r_state     <= S_ERR1;
                r_cnt       <= '0;
                r_hreadyout <= 1'b0;
                r_hresp     <= 1'b1;
            end else begin
                r_state     <= S_DATA;
                r_cnt       <= c_CW'(WAIT_STATES);
                r_hreadyout <= (WAIT_STATES == 0);
                r_hresp     <= 1'b0;
            end
        end else begin
            case (r_state)
                S_DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt       <= r_cnt - c_CW'(1);
                        // Ready rises together with the counter reaching zero.
                        r_hreadyout <= (r_cnt == c_CW'(1));
                    end else begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage: byte-lane writes on the final data cycle, synchronous read
    // captured at the address-phase accept. A write committing on that same
    // edge to the same word is forwarded lane by lane so back-to-back
    // write->read returns the new data.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_widx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
        if (w_accept && !w_err && !HWRITE) begin
            for (int i = 0; i < 4; i++) begin
                r_rdbuf[8*i +: 8] <= (w_commit && w_be[i] && (r_widx == w_aidx))
                                     ? HWDATA[8*i +: 8]
                                     : r_mem[w_aidx][8*i +: 8];
            end
        end
    end

    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign HRDATA    = (w_final && !r_write) ? r_rdbuf : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_sram_slave
// Description : Scoreboard bench for ahb_sram_slave. Two instances: one with
//               no wait states, one with two. Each issued transfer pushes its
//               per-cycle expected data-phase response; a negedge monitor pops
//               and compares on every data-phase cycle and checks idle output
//               values otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;

    typedef struct {
        logic        rdy;
        logic        resp;
        logic [31:0] rd;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel      [2];
    logic [15:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [31:0] hwdata    [2];
    logic [31:0] hrdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [2:0]  hburst = 3'b001;
    logic [3:0]  hprot  = 4'h3;
    logic        act0, act1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst), .HPROT(hprot),
        .HWDATA(hwdata[0]), .HREADY(hreadyout[0]), .HRDATA(hrdata[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
    );

    ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(2)) u_dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst), .HPROT(hprot),
        .HWDATA(hwdata[1]), .HREADY(hreadyout[1]), .HRDATA(hrdata[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
    );

    // Bus-level data-phase tracking: a data phase starts when a selected
    // NONSEQ/SEQ meets HREADY high and lasts until HREADY is high again.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act0 <= 1'b0;
            act1 <= 1'b0;
        end else begin
            if (hreadyout[0]) act0 <= hsel[0] & htrans[0][1];
            if (hreadyout[1]) act1 <= hsel[1] & htrans[1][1];
        end
    end

    task automatic cmp(input int d, input string nm, input logic [33:0] got, input logic [33:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL dut%0d %s: got rdy=%0b resp=%0b rdata=%08h, want rdy=%0b resp=%0b rdata=%08h",
                     d, nm, got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
        end
    endtask

    task automatic mon_one(input int d);
        exp_t        e;
        logic [33:0] a;
        logic        in_phase;
        int          qs;
        a        = {hreadyout[d], hresp[d], hrdata[d]};
        in_phase = (d == 0) ? act0 : act1;
        qs       = (d == 0) ? q0.size() : q1.size();
        if (rst) begin
            if (d == 0) q0.delete(); else q1.delete();
            cmp(d, "reset outputs", a, {1'b1, 1'b0, 32'h0});
        end else if (in_phase) begin
            if (qs == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dut%0d unexpected data phase: got %09h, want no transfer", d, a);
            end else begin
                if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                cmp(d, e.nm, a, {e.rdy, e.resp, e.rd});
            end
        end else begin
            cmp(d, "idle outputs", a, {1'b1, 1'b0, 32'h0});
        end
    endtask

    always @(negedge clk) begin
        mon_one(0);
        mon_one(1);
    end

    task automatic push_exp(input int d, input logic rdy, input logic resp, input logic [31:0] rd, input string nm);
        exp_t e;
        e.rdy  = rdy;
        e.resp = resp;
        e.rd   = rd;
        e.nm   = nm;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Issue one transfer; called at posedge+1, returns at posedge+1 after the
    // accepting edge with the bus idle and HWDATA set for the data phase.
    task automatic xfer(input int d, input logic [1:0] tr, input logic wr, input logic [15:0] a,
                        input logic [2:0] sz, input logic [31:0] wd, input logic err,
                        input logic [31:0] exp_rd, input string nm);
        bit ok;
        int ws;
        hsel[d]   = 1'b1;
        htrans[d] = tr;
        hwrite[d] = wr;
        haddr[d]  = a;
        hsize[d]  = sz;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hreadyout[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL dut%0d %s: HREADYOUT stayed 0 for 20 cycles, want 1", d, nm);
        end
        @(posedge clk);
        #1;
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        hwdata[d] = wd;
        ws = (d == 0) ? 0 : 2;
        if (err) begin
            push_exp(d, 1'b0, 1'b1, 32'h0, {nm, " err1"});
            push_exp(d, 1'b1, 1'b1, 32'h0, {nm, " err2"});
        end else begin
            for (int i = 0; i < ws; i++) push_exp(d, 1'b0, 1'b0, 32'h0, {nm, " wait"});
            push_exp(d, 1'b1, 1'b0, wr ? 32'h0 : exp_rd, nm);
        end
    endtask

    task automatic bus_cycle(input int d, input logic sel, input logic [1:0] tr);
        hsel[d]   = sel;
        htrans[d] = tr;
        haddr[d]  = 16'h0040;
        @(posedge clk);
        #1;
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
    endtask

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    initial begin
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b0; haddr[d] = 16'h0; htrans[d] = 2'b00;
            hwrite[d] = 1'b0; hsize[d] = 3'd0; hwdata[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // word write then read
        xfer(0, NS, 1, 16'h0010, 3'd2, 32'hDEADBEEF, 0, 32'h0, "wr 0010");
        bus_cycle(0, 1'b0, NS);
        bus_cycle(0, 1'b1, 2'b01);
        xfer(0, NS, 0, 16'h0010, 3'd2, 32'h0, 0, 32'hDEADBEEF, "rd 0010");

        // byte lanes
        xfer(0, NS, 1, 16'h0020, 3'd2, 32'h00000000, 0, 32'h0, "wr 0020 zero");
        xfer(0, NS, 1, 16'h0022, 3'd0, 32'h00AA0000, 0, 32'h0, "wr byte 0022");
        xfer(0, NS, 1, 16'h0020, 3'd1, 32'h00001234, 0, 32'h0, "wr half 0020");
        xfer(0, NS, 0, 16'h0020, 3'd2, 32'h0, 0, 32'h00AA1234, "rd 0020 lanes");
        xfer(0, SQ, 0, 16'h0023, 3'd0, 32'h0, 0, 32'h00AA1234, "seq byte rd 0023");

        // errors leave memory intact
        xfer(0, NS, 1, 16'h0000, 3'd2, 32'h11223344, 0, 32'h0, "wr 0000");
        xfer(0, NS, 1, 16'h0002, 3'd2, 32'hFFFFFFFF, 1, 32'h0, "err misaligned word");
        xfer(0, NS, 1, 16'h1000, 3'd2, 32'hFFFFFFFF, 1, 32'h0, "err out of range");
        xfer(0, NS, 1, 16'h0000, 3'd3, 32'hFFFFFFFF, 1, 32'h0, "err size 3");
        xfer(0, NS, 1, 16'h0001, 3'd1, 32'hFFFFFFFF, 1, 32'h0, "err misaligned half");
        xfer(0, NS, 0, 16'h0000, 3'd2, 32'h0, 0, 32'h11223344, "rd 0000 after errors");

        // back-to-back write->read
        xfer(0, NS, 1, 16'h0008, 3'd2, 32'h5555AAAA, 0, 32'h0, "wr 0008");
        xfer(0, NS, 0, 16'h0008, 3'd2, 32'h0, 0, 32'h5555AAAA, "b2b rd 0008");

        // top of the window
        xfer(0, NS, 1, 16'h0FFC, 3'd2, 32'hA5A55A5A, 0, 32'h0, "wr 0FFC");
        xfer(0, NS, 1, 16'h0FFF, 3'd0, 32'h7E000000, 0, 32'h0, "wr byte 0FFF");
        xfer(0, NS, 0, 16'h0FFC, 3'd2, 32'h0, 0, 32'h7EA55A5A, "rd 0FFC");
        xfer(0, NS, 0, 16'h0FFE, 3'd1, 32'h0, 0, 32'h7EA55A5A, "rd half 0FFE");

        // wait states on the second instance
        xfer(1, NS, 1, 16'h0004, 3'd2, 32'hCAFEF00D, 0, 32'h0, "ws2 wr 0004");
        xfer(1, NS, 0, 16'h0004, 3'd2, 32'h0, 0, 32'hCAFEF00D, "ws2 rd 0004");
        repeat (4) bus_cycle(0, 1'b0, 2'b00);

        // reset asserted during ERR1
        xfer(0, NS, 0, 16'h1000, 3'd2, 32'h0, 1, 32'h0, "err before reset");
        #1 rst = 1'b1;
        #1 cmp(0, "async reset in ERR1", {hreadyout[0], hresp[0], hrdata[0]}, {1'b1, 1'b0, 32'h0});
        @(posedge clk);
        #1 rst = 1'b0;
        xfer(0, NS, 0, 16'h0010, 3'd2, 32'h0, 0, 32'hDEADBEEF, "rd 0010 after reset");

        repeat (4) bus_cycle(0, 1'b0, 2'b00);
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL queues drained: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit storage words; the valid byte window is 0 .. MEM_WORDS*4-1.
REQ-002 SHALL have parameter WAIT_STATES, default 0, meaning the number of HREADYOUT-low cycles inserted in every OKAY data phase.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
- HCLK  in  1  clock; all state changes on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  16  byte address.
- HTRANS  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word.
- HBURST  in  3  ignored.
- HPROT  in  4  ignored.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus ready (previous transfer complete).
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-004 SHALL accept a transfer when HSEL=1, HTRANS[1]=1 and HREADY=1, registering HADDR, HWRITE and HSIZE at that edge.
REQ-005 SHALL answer IDLE, BUSY or unselected cycles with HREADYOUT=1 and HRESP=0, with zero wait states.
REQ-006 SHALL flag an accepted transfer as an error if any of these holds:
- HSIZE>2;
- HSIZE=1 and HADDR[0]=1;
- HSIZE=2 and HADDR[1:0]!=0;
- HADDR>=MEM_WORDS*4.
REQ-007 SHALL implement an FSM with states IDLE, DATA, ERR1 and ERR2.
REQ-008 SHALL make the following transitions:
- IDLE/DATA/ERR2 on a valid accept -> DATA;
- IDLE/DATA/ERR2 on an error accept -> ERR1;
- IDLE/DATA/ERR2 otherwise -> IDLE;
- ERR1 -> ERR2 unconditionally.
REQ-009 SHALL, in DATA, drive HREADYOUT=0 for WAIT_STATES cycles using a down-counter loaded on accept, then HREADYOUT=1 with HRESP=0.
REQ-010 SHALL drive HREADYOUT=0, HRESP=1 in ERR1 and HREADYOUT=1, HRESP=1 in ERR2, forming the two-cycle AHB error response.
REQ-011 SHALL commit a write only on the final DATA cycle (HREADYOUT=1), using HWDATA sampled on that edge.
REQ-012 SHALL update only the byte lanes selected by the registered addr[1:0] and size:
- byte: lane addr[1:0];
- halfword: lanes addr[1]*2 and addr[1]*2+1;
- word: all four lanes.
REQ-013 SHALL leave memory unchanged by erroring transfers.
REQ-014 SHALL drive HRDATA with the full 32-bit word at registered addr[..:2] during the final DATA cycle of a read, regardless of HSIZE, and drive 0 at all other times.
REQ-015 SHALL return read data that reflects every write committed earlier, including a write committed on the cycle immediately before the read's final DATA cycle (back-to-back write->read to the same word); a synchronous RAM implementation SHALL forward to achieve this.
REQ-016 SHALL accept a new address phase in the same cycle its current data phase completes (pipelined operation).
REQ-017 SHALL not accept a transfer during ERR1 or wait cycles because HREADY is low.
REQ-018 SHALL treat a SEQ transfer identically to a NONSEQ transfer; burst boundaries are not checked.

Reset
REQ-019 SHALL, on HRESET=1 asynchronously, force the following values and hold them while HRESET=1:
- FSM -> IDLE;
- wait counter -> 0;
- HREADYOUT=1;
- HRESP=0;
- HRDATA=0.
REQ-020 SHALL discard any pending write or error response when reset asserts mid-transfer.
REQ-021 SHALL leave memory contents unchanged by reset (contents are undefined at power-up).
REQ-022 SHALL accept a transfer on the first rising edge after HRESET deasserts.

Verification
REQ-023 SHALL cover a word write then read: write 0xDEADBEEF to 0x0010, then read 0x0010 -> HRDATA=0xDEADBEEF, HRESP=0, no wait states (WAIT_STATES=0).
REQ-024 SHALL cover byte lanes: word 0x0020=0x00000000; byte write 0xAA to 0x0022 (HWDATA=0x00AA0000); halfword write 0x1234 to 0x0020 (HWDATA=0x00001234) -> read 0x0020 = 0x00AA1234.
REQ-025 SHALL cover errors: word access to 0x0002, and access to 0x1000 with MEM_WORDS=1024.
- Each -> HREADYOUT 0 then 1, with HRESP=1 on both cycles.
- A following read of 0x0000 shows no corruption.
REQ-026 SHALL cover wait states with WAIT_STATES=2: a read of 0x0004 -> HREADYOUT low for exactly 2 cycles, then high with valid data.
REQ-027 SHALL cover back-to-back transfers: write 0x5555AAAA to 0x0008 immediately followed by a read of 0x0008 -> read returns 0x5555AAAA.
REQ-028 SHALL cover reset mid-transfer: assert HRESET during the ERR1 cycle -> HREADYOUT=1, HRESP=0 immediately; the next accepted read of 0x0010 returns its pre-reset contents.
